// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcode values, instruction field bit
// positions and widths, the skid-buffer occupancy encoding, and a helper
// that says whether an opcode's 16-bit immediate is sign-extended.
package mips_pkg;

   localparam int INSTR_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_MSB  = 10;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;
   localparam int IMM_MSB    = 15;
   localparam int IMM_LSB    = 0;
   localparam int JADDR_MSB  = 25;
   localparam int JADDR_LSB  = 0;

   localparam int OPCODE_W = 6;
   localparam int REG_W    = 5;
   localparam int FUNCT_W  = 6;
   localparam int IMM_W    = 16;
   localparam int JADDR_W  = 26;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } buf_state_e;

   // Logical immediates (andi/ori/xori/lui) and everything not listed
   // here zero-extend.
   function automatic logic imm_sign_ext(input logic [5:0] op);
      logic s;
      s = 1'b0;
      case (op)
         OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
         OP_SLTI, OP_SLTIU, OP_LW, OP_SW: s = 1'b1;
         default:                          s = 1'b0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Generic two-entry valid/ready buffer with flush.
// Ports: clk, rst (async active-high), flush; upstream in_valid/in_ready/
// in_data; downstream out_valid/out_ready/out_data (out_data = head entry).
//
// state    | meaning
// ST_EMPTY | no entry held, head keeps its last value
// ST_ONE   | head valid, skid empty
// ST_TWO   | head and skid valid, upstream stalled
module skid_buffer2
   import mips_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   buf_state_e        state_q, state_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              in_ready_q, in_ready_d;
   logic              accept, pop;

   assign out_valid = (state_q != ST_EMPTY);
   assign in_ready  = in_ready_q;
   assign out_data  = head_q;
   assign accept    = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         head_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         head_q     <= head_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  head_d  = in_data;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && pop) begin
                  head_d = in_data;
               end else if (accept) begin
                  skid_d  = in_data;
                  state_d = ST_TWO;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  head_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      // Registered ready: a stall is announced the edge the skid fills.
      in_ready_d = (state_d != ST_TWO);
   end

endmodule

// File: rtl/if_id_stage.sv
// Fetch-to-decode pipeline stage. Buffers {instr, pc} in a two-entry skid
// buffer and presents the head word split into MIPS fields.
// Ports: clk, rst (async active-high); fetch side in_valid/in_ready/
// in_instr/in_pc; flush; decode side out_valid/out_ready/out_pc plus the
// field slices opcode, rs, rt, rd, shamt, funct, imm16, jaddr, and the
// derived ext_sign (1 = sign-extend imm16) and is_nop.
module if_id_stage
   import mips_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int PC_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [5:0]         opcode,
   output logic [4:0]         rs,
   output logic [4:0]         rt,
   output logic [4:0]         rd,
   output logic [4:0]         shamt,
   output logic [5:0]         funct,
   output logic [15:0]        imm16,
   output logic [25:0]        jaddr,
   output logic               ext_sign,
   output logic               is_nop
);

   localparam int DATA_W = INSTR_W + PC_W;

   logic [DATA_W-1:0]  head;
   logic [INSTR_W-1:0] instr;

   skid_buffer2 #(.DATA_W(DATA_W)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_instr, in_pc}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head)
   );

   assign instr  = head[DATA_W-1:PC_W];
   assign out_pc = head[PC_W-1:0];

   assign opcode   = instr[OPCODE_MSB:OPCODE_LSB];
   assign rs       = instr[RS_MSB:RS_LSB];
   assign rt       = instr[RT_MSB:RT_LSB];
   assign rd       = instr[RD_MSB:RD_LSB];
   assign shamt    = instr[SHAMT_MSB:SHAMT_LSB];
   assign funct    = instr[FUNCT_MSB:FUNCT_LSB];
   assign imm16    = instr[IMM_MSB:IMM_LSB];
   assign jaddr    = instr[JADDR_MSB:JADDR_LSB];
   assign ext_sign = imm_sign_ext(opcode);
   assign is_nop   = (instr == '0);

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [31:0] in_instr, in_pc;
   logic        flush;
   logic        out_valid, out_ready;
   logic [31:0] out_pc;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic [25:0] jaddr;
   logic        ext_sign, is_nop;

   int n_vec = 0;
   int n_err = 0;

   if_id_stage #(.INSTR_W(32), .PC_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .funct(funct), .imm16(imm16), .jaddr(jaddr),
      .ext_sign(ext_sign), .is_nop(is_nop)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; flush = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      out_ready = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
      #1;
   endtask

   task automatic check_idle(input string tag);
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s out_valid got %b want 0", tag, out_valid); end
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s in_ready got %b want 1", tag, in_ready); end
      n_vec++;
      if ({opcode, rs, rt, rd, shamt, funct, imm16, jaddr, out_pc} !== '0) begin
         n_err++; $display("FAIL %s fields got op=%h imm=%h jaddr=%h pc=%h want all 0", tag, opcode, imm16, jaddr, out_pc);
      end
      n_vec++;
      if (ext_sign !== 1'b0 || is_nop !== 1'b1) begin
         n_err++; $display("FAIL %s ext_sign/is_nop got %b/%b want 0/1", tag, ext_sign, is_nop);
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_idle("reset");
      cycle();
      check_idle("reset_idle");
   endtask

   task automatic test_single_lw();
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 32'h8C22_ABCD; in_pc = 32'h100;
      cycle();
      idle_inputs();
      n_vec++;
      if (out_valid !== 1'b1) begin n_err++; $display("FAIL lw_valid got %b want 1", out_valid); end
      n_vec++;
      if (opcode !== 6'h23 || rs !== 5'd1 || rt !== 5'd2) begin
         n_err++; $display("FAIL lw_op_rs_rt got %h/%0d/%0d want 23/1/2", opcode, rs, rt);
      end
      n_vec++;
      if (rd !== 5'h15 || shamt !== 5'h0F || funct !== 6'h0D) begin
         n_err++; $display("FAIL lw_rd_shamt_funct got %h/%h/%h want 15/0f/0d", rd, shamt, funct);
      end
      n_vec++;
      if (imm16 !== 16'hABCD || jaddr !== 26'h022ABCD) begin
         n_err++; $display("FAIL lw_imm_jaddr got %h/%h want abcd/022abcd", imm16, jaddr);
      end
      n_vec++;
      if (ext_sign !== 1'b1 || is_nop !== 1'b0) begin
         n_err++; $display("FAIL lw_ext_nop got %b/%b want 1/0", ext_sign, is_nop);
      end
      n_vec++;
      if (out_pc !== 32'h100) begin n_err++; $display("FAIL lw_pc got %h want 100", out_pc); end
      cycle();
      n_vec++;
      if (out_valid !== 1'b0 || opcode !== 6'h23) begin
         n_err++; $display("FAIL lw_popped valid/opcode got %b/%h want 0/23", out_valid, opcode);
      end
   endtask

   task automatic test_ori();
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 32'h3443_0123; in_pc = 32'h104;
      cycle();
      idle_inputs();
      n_vec++;
      if (out_valid !== 1'b1 || opcode !== 6'h0D || imm16 !== 16'h0123 || ext_sign !== 1'b0) begin
         n_err++; $display("FAIL ori got v=%b op=%h imm=%h ext=%b want 1/0d/0123/0", out_valid, opcode, imm16, ext_sign);
      end
      n_vec++;
      if (rs !== 5'd2 || rt !== 5'd3) begin n_err++; $display("FAIL ori_regs got %0d/%0d want 2/3", rs, rt); end
      cycle();
   endtask

   task automatic test_ext_sign();
      logic [5:0] ops [16];
      logic       exp [16];
      ops = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B,
              6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h00, 6'h02, 6'h20, 6'h3F};
      exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_valid = 1'b1; in_instr = {ops[i], 26'h0000_8001}; in_pc = 32'h300 + 32'(i * 4);
         cycle();
         idle_inputs();
         n_vec++;
         if (out_valid !== 1'b1 || opcode !== ops[i] || ext_sign !== exp[i]) begin
            n_err++; $display("FAIL ext_sign op=%h got v=%b op=%h ext=%b want ext=%b", ops[i], out_valid, opcode, ext_sign, exp[i]);
         end
      end
      in_valid = 1'b1; in_instr = 32'h0; in_pc = 32'h400;
      cycle();
      idle_inputs();
      n_vec++;
      if (out_valid !== 1'b1 || is_nop !== 1'b1) begin n_err++; $display("FAIL nop got v=%b nop=%b want 1/1", out_valid, is_nop); end
      in_valid = 1'b1; in_instr = 32'h0000_0040; in_pc = 32'h404;
      cycle();
      idle_inputs();
      n_vec++;
      if (is_nop !== 1'b0 || shamt !== 5'd1) begin n_err++; $display("FAIL not_nop got nop=%b shamt=%0d want 0/1", is_nop, shamt); end
      cycle();
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc [4];
      int   idx;
      logic acc;
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC};
      idx = 0;
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = (idx < 4); in_pc = exp_pc[idx[1:0]]; in_instr = 32'h2000_0000 | idx;
         acc = in_valid & in_ready;
         cycle();
         if (acc) idx++;
         if (c == 1) begin
            n_vec++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_drop got %b want 0", in_ready); end
         end
      end
      n_vec++;
      if (idx != 2 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
         n_err++; $display("FAIL bp_hold accepted=%0d v=%b pc=%h want 2/1/0", idx, out_valid, out_pc);
      end
      // Data on the bus while stalled must not be captured.
      in_instr = 32'hDEAD_BEEF;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = (idx < 4); in_pc = exp_pc[idx[1:0]]; in_instr = 32'h2000_0000 | idx;
         n_vec++;
         if (out_valid !== 1'b1 || out_pc !== exp_pc[k] || imm16 !== 16'(k)) begin
            n_err++; $display("FAIL bp_drain[%0d] got v=%b pc=%h imm=%h want 1/%h/%h", k, out_valid, out_pc, imm16, exp_pc[k], k);
         end
         acc = in_valid & in_ready;
         cycle();
         if (acc) idx++;
      end
      idle_inputs();
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL bp_empty got v=%b rdy=%b want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h2000_0040; in_pc = 32'h40;
      cycle();
      in_instr = 32'h2000_0044; in_pc = 32'h44;
      cycle();
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_err++; $display("FAIL flush_setup got rdy=%b v=%b want 0/1", in_ready, out_valid); end
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h2000_0048; in_pc = 32'h48;
      cycle();
      idle_inputs();
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++; $display("FAIL flush_two got v=%b rdy=%b want 0/1", out_valid, in_ready);
      end
      // Flush from EMPTY with a word that would otherwise be accepted.
      out_ready = 1'b1;
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h2000_0050; in_pc = 32'h50;
      cycle();
      idle_inputs();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop got v=%b pc=%h want 0", out_valid, out_pc); end
      cycle();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stay_empty got v=%b want 0", out_valid); end
      in_valid = 1'b1; in_instr = 32'h2000_0060; in_pc = 32'h60;
      cycle();
      idle_inputs();
      n_vec++;
      if (out_valid !== 1'b1 || out_pc !== 32'h60) begin
         n_err++; $display("FAIL flush_recover got v=%b pc=%h want 1/60", out_valid, out_pc);
      end
      cycle();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h8C22_0001; in_pc = 32'h70;
      cycle();
      in_pc = 32'h74;
      cycle();
      idle_inputs();
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_setup rdy got %b want 0", in_ready); end
      #2;
      rst = 1'b1;
      #1;
      check_idle("rst_async");
      cycle();
      rst = 1'b0;
      #1;
      check_idle("rst_after");
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            n_vec++;
            if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); end
         end
         if (i > 0) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'((i - 1) * 4)) begin
               n_err++; $display("FAIL b2b_out[%0d] got v=%b pc=%h want 1/%h", i, out_valid, out_pc, 32'h200 + 32'((i - 1) * 4));
            end
         end
         in_valid = (i < 8); in_instr = 32'h2400_0000 | i; in_pc = 32'h200 + 32'(i * 4);
         cycle();
      end
      idle_inputs();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got v=%b want 0", out_valid); end
   endtask

   initial begin
      rst = 1'b1;
      out_ready = 1'b0;
      idle_inputs();
      test_reset();
      test_single_lw();
      test_ori();
      test_ext_sign();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
